leaf_bft_endpoint: RTL

//  BFT-side peer of a page leaf: packs a 32-bit source stream into 49-bit BFT packets addressed
//  to one (leaf, port), and unpacks packets arriving from the BFT into a 32-bit sink stream.

---
 rtl/leaf_bft_endpoint.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/leaf_bft_endpoint.sv
// BFT-side peer of a page leaf: packs a source stream into credit-limited BFT packets and
// unpacks arriving BFT data packets into a FWFT receive FIFO that returns freespace credit.
module leaf_bft_endpoint #(
    parameter int PACKET_BITS           = 49,
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_LEAF_BITS         = 5,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int RX_DEPTH              = 128,
    parameter int FREESPACE_UPDATE_SIZE = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_LEAF_BITS-1:0] dest_leaf,
    input  logic [NUM_PORT_BITS-1:0] dest_port,
    input  logic [PAYLOAD_BITS-1:0]  tx_data,
    input  logic                     tx_valid,
    output logic                     tx_ready,
    output logic [PACKET_BITS-1:0]   dout_bft,
    input  logic [PACKET_BITS-1:0]   din_bft,
    output logic [PAYLOAD_BITS-1:0]  rx_data,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic [NUM_ADDR_BITS:0]   credit,
    output logic [15:0]              rx_drop_cnt
);

    localparam int CRED_W  = NUM_ADDR_BITS + 1;
    localparam int SUM_W   = CRED_W + 2;
    localparam int PTR_W   = $clog2(RX_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int CONS_W  = $clog2(FREESPACE_UPDATE_SIZE);
    localparam int ADDR_LO = PAYLOAD_BITS;
    localparam int PORT_LO = ADDR_LO + NUM_ADDR_BITS;
    localparam int LEAF_LO = PORT_LO + NUM_PORT_BITS;
    localparam logic [CRED_W-1:0] CREDIT_MAX = CRED_W'(1) << NUM_ADDR_BITS;

    function automatic logic [PACKET_BITS-1:0] pack_pkt(
        input logic [NUM_LEAF_BITS-1:0] leaf,
        input logic [NUM_PORT_BITS-1:0] port,
        input logic [NUM_ADDR_BITS-1:0] addr,
        input logic [PAYLOAD_BITS-1:0]  payload
    );
        return {1'b1, leaf, port, addr, payload};
    endfunction

    logic [CRED_W-1:0]        credit_q, credit_d;
    logic [NUM_ADDR_BITS-1:0] seq_q, seq_d;
    logic [CONS_W-1:0]        consumed_q, consumed_d;
    logic                     pending_fs_q, pending_fs_d;
    logic [NUM_LEAF_BITS-1:0] fs_leaf_q, fs_leaf_d;
    logic [PACKET_BITS-1:0]   dout_q, dout_d;
    logic                     tx_ready_q, tx_ready_d;
    logic [15:0]              drop_cnt_q, drop_cnt_d;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [PAYLOAD_BITS-1:0]  mem_q [RX_DEPTH];

    logic                     din_valid_s, fs_in_s, data_in_s;
    logic [NUM_PORT_BITS-1:0] din_port_s;
    logic [NUM_LEAF_BITS-1:0] din_leaf_s;
    logic [PAYLOAD_BITS-1:0]  din_payload_s;
    logic                     send_data_s, pop_s, push_s, drop_s, fifo_full_s;
    logic [7:0]               credit_inc_s;
    logic [SUM_W-1:0]         credit_sum_s;
    logic                     unused_s;

    assign din_valid_s   = din_bft[PACKET_BITS-1];
    assign din_leaf_s    = din_bft[LEAF_LO +: NUM_LEAF_BITS];
    assign din_port_s    = din_bft[PORT_LO +: NUM_PORT_BITS];
    assign din_payload_s = din_bft[PAYLOAD_BITS-1:0];
    // The sequence field of incoming packets carries no meaning for this endpoint.
    assign unused_s      = ^din_bft[ADDR_LO +: NUM_ADDR_BITS];

    assign fs_in_s      = din_valid_s && (din_port_s == '0);
    assign data_in_s    = din_valid_s && (din_port_s != '0);
    assign send_data_s  = tx_valid && tx_ready_q;
    assign pop_s        = (count_q != '0) && rx_ready;
    assign fifo_full_s  = (count_q == CNT_W'(RX_DEPTH));
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign push_s       = data_in_s && (!fifo_full_s || pop_s);
    assign drop_s       = data_in_s && !push_s;

    assign tx_ready     = tx_ready_q;
    assign dout_bft     = dout_q;
    assign credit       = credit_q;
    assign rx_drop_cnt  = drop_cnt_q;
    assign rx_valid     = (count_q != '0);
    assign rx_data      = mem_q[rd_ptr_q];

    // Next-state logic for credit, sequence, credit return and the outgoing packet.
    always_comb begin
        credit_inc_s = 8'd0;
        if (fs_in_s) begin
            credit_inc_s = din_payload_s[7:0];
        end else begin
            credit_inc_s = 8'd0;
        end

        credit_sum_s = SUM_W'(credit_q) + SUM_W'(credit_inc_s) - SUM_W'(send_data_s);
        if (credit_sum_s > SUM_W'(CREDIT_MAX)) begin
            credit_d = CREDIT_MAX;
        end else begin
            credit_d = credit_sum_s[CRED_W-1:0];
        end

        if (send_data_s) begin
            seq_d = seq_q + NUM_ADDR_BITS'(1);
        end else begin
            seq_d = seq_q;
        end

        consumed_d   = consumed_q;
        pending_fs_d = pending_fs_q ? 1'b0 : pending_fs_q;
        if (pop_s) begin
            if (consumed_q == CONS_W'(FREESPACE_UPDATE_SIZE - 1)) begin
                consumed_d   = '0;
                pending_fs_d = 1'b1;
            end else begin
                consumed_d   = consumed_q + CONS_W'(1);
            end
        end else begin
            consumed_d = consumed_q;
        end

        // Freespace return wins; tx_ready is already low while it is pending.
        if (pending_fs_q) begin
            dout_d = pack_pkt(fs_leaf_q, NUM_PORT_BITS'(0), NUM_ADDR_BITS'(0),
                              PAYLOAD_BITS'(FREESPACE_UPDATE_SIZE));
        end else if (send_data_s) begin
            dout_d = pack_pkt(dest_leaf, dest_port, seq_q, tx_data);
        end else begin
            dout_d = '0;
        end

        tx_ready_d = (credit_d != '0) && !pending_fs_d;

        if (data_in_s) begin
            fs_leaf_d = din_leaf_s;
        end else begin
            fs_leaf_d = fs_leaf_q;
        end

        if (drop_s && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Receive FIFO pointer and occupancy bookkeeping.
    always_comb begin
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
    end

    // State registers; reset clears any in-flight packet and discards buffered rx words.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credit_q     <= CREDIT_MAX;
            seq_q        <= '0;
            consumed_q   <= '0;
            pending_fs_q <= 1'b0;
            fs_leaf_q    <= '0;
            dout_q       <= '0;
            tx_ready_q   <= 1'b0;
            drop_cnt_q   <= 16'd0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            credit_q     <= credit_d;
            seq_q        <= seq_d;
            consumed_q   <= consumed_d;
            pending_fs_q <= pending_fs_d;
            fs_leaf_q    <= fs_leaf_d;
            dout_q       <= dout_d;
            tx_ready_q   <= tx_ready_d;
            drop_cnt_q   <= drop_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Receive FIFO storage; contents are qualified by the pointers, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= din_payload_s;
        end
    end

endmodule
